// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI/BIST RAM arbiter: FSM states, RAM opcodes and the 10-bit RAM beat.
package spi_ram_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BEAT_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT_RD,
        RESP
    } state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] payload;
    } ram_beat_t;

    function automatic ram_beat_t make_beat(input logic [1:0] op, input logic [DATA_W-1:0] payload);
        ram_beat_t beat;
        beat.op      = op;
        beat.payload = payload;
        return beat;
    endfunction

endpackage

// File: rtl/ram_arb_picker.sv
// Two-way grant: a lone requester always wins; on a tie the favoured index wins.
module ram_arb_picker (
    input  logic [1:0] req_valid,
    input  logic       prio,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = req_valid;
        if (&req_valid) begin
            grant_c = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares the single-port RAM between two requesters and sequences its two-beat command protocol.
// Define SPI_RAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RD_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [15:0]         req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_err,
    output logic [9:0]          ram_din,
    output logic                ram_rx_valid,
    input  logic [7:0]          ram_dout,
    input  logic                ram_tx_valid,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    ram_beat_t           ram_din_q, ram_din_d;
    logic                ram_rx_valid_q, ram_rx_valid_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;

    logic [1:0]          grant_c;
    logic                prio_c;
    logic                hs_c;
    logic                sel_c;
    logic                sel_we_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;

    ram_arb_picker u_picker (
        .req_valid (req_valid),
        .prio      (prio_c),
        .grant_c   (grant_c)
    );

    // Grant is only exposed while idle and out of reset.
    assign req_ready   = (state_q == IDLE && arst_n) ? grant_c : 2'b00;
    assign hs_c        = |req_ready;
    assign sel_c       = grant_c[1];
    assign sel_we_c    = req_we[sel_c];
    assign sel_addr_c  = sel_c ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign sel_wdata_c = sel_c ? req_wdata[15:8] : req_wdata[7:0];

`ifdef SPI_RAM_ARB_RR_EN
    logic prio_q, prio_d;

    // Favour whoever was not just granted.
    always_comb begin
        prio_d = prio_q;
        if (hs_c) begin
            prio_d = ~sel_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio_c = prio_q;
`else
    assign prio_c = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        ram_din_d      = '0;
        ram_rx_valid_d = 1'b0;
        rsp_valid_d    = 2'b00;
        rsp_rdata_d    = '0;
        rsp_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs_c) begin
                    owner_d        = sel_c;
                    we_d           = sel_we_c;
                    addr_d         = sel_addr_c;
                    wdata_d        = sel_wdata_c;
                    state_d        = ADDR;
                    ram_rx_valid_d = 1'b1;
                    ram_din_d      = make_beat(sel_we_c ? OP_WR_ADDR : OP_RD_ADDR, DATA_W'(sel_addr_c));
                end
            end
            ADDR: begin
                state_d        = DATA;
                ram_rx_valid_d = 1'b1;
                ram_din_d      = make_beat(we_q ? OP_WR_DATA : OP_RD_DATA, we_q ? wdata_q : '0);
            end
            DATA: begin
                if (we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                end else begin
                    state_d = WAIT_RD;
                    cnt_d   = '0;
                end
            end
            WAIT_RD: begin
                if (ram_tx_valid) begin
                    state_d     = RESP;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = ram_dout;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= '0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            rsp_valid_q    <= 2'b00;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            cnt_q          <= cnt_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            busy_q         <= busy_d;
        end
    end

    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: behavioural RAM stub, transaction-level reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_spi_ram_arbiter;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned RD_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = 2'b00;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic [7:0]  ram_dout = 8'h00;
    logic        ram_tx_valid = 1'b0;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit stub_dead = 1'b0;

    spi_ram_arbiter #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM stub: latches address beats, writes on write-data beats, returns data one cycle after a read-data beat.
    logic [7:0] ram_mem [256];
    logic [7:0] ram_areg = 8'h00;
    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00, 2'b10: ram_areg <= ram_din[7:0];
                2'b01:        ram_mem[ram_areg] <= ram_din[7:0];
                default: if (!stub_dead) begin
                    ram_tx_valid <= 1'b1;
                    ram_dout     <= ram_mem[ram_areg];
                end
            endcase
        end
    end

    // Reference model: one transaction at a time, outputs expressed as offsets from the handshake edge.
    logic [7:0] ref_mem [256];
    bit         m_act = 1'b0;
    int         m_k = 0;
    int         m_rsp_k = 0;
    bit         m_owner = 1'b0;
    bit         m_we = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    bit         m_err = 1'b0;
    bit         m_last = 1'b1;

    function automatic logic [1:0] pick(input logic [1:0] v);
        bit fav;
`ifdef SPI_RAM_ARB_RR_EN
        fav = ~m_last;
`else
        fav = 1'b0;
`endif
        if (v == 2'b11) return fav ? 2'b10 : 2'b01;
        return v;
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        if (!arst_n) begin
            m_act  = 1'b0;
            m_last = 1'b1;
        end else if (m_act) begin
            if (m_k == m_rsp_k) m_act = 1'b0;
            else m_k++;
        end else begin
            g = pick(req_valid);
            if (g != 2'b00) begin
                m_owner = g[1];
                m_we    = req_we[m_owner];
                m_addr  = m_owner ? req_addr[15:8] : req_addr[7:0];
                m_wdata = m_owner ? req_wdata[15:8] : req_wdata[7:0];
                m_last  = m_owner;
                m_act   = 1'b1;
                m_k     = 1;
                if (m_we) begin
                    ref_mem[m_addr] = m_wdata;
                    m_rsp_k = 3;
                    m_rdata = 8'h00;
                    m_err   = 1'b0;
                end else if (stub_dead) begin
                    m_rsp_k = 3 + RD_TIMEOUT;
                    m_rdata = 8'h00;
                    m_err   = 1'b1;
                end else begin
                    m_rsp_k = 4;
                    m_rdata = ref_mem[m_addr];
                    m_err   = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [1:0] e_ready, e_rsp;
        bit         e_rx;
        logic [9:0] e_din;
        if (chk_en) begin
            e_ready = (!m_act && arst_n) ? pick(req_valid) : 2'b00;
            e_rx    = m_act && (m_k == 1 || m_k == 2);
            e_din   = (m_k == 1) ? {(m_we ? 2'b00 : 2'b10), m_addr}
                                 : {(m_we ? 2'b01 : 2'b11), (m_we ? m_wdata : 8'h00)};
            e_rsp   = (m_act && m_k == m_rsp_k) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(m_act));
            chk("ram_rx_valid", 32'(ram_rx_valid), 32'(e_rx));
            if (e_rx) chk("ram_din", 32'(ram_din), 32'(e_din));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            if (e_rsp != 2'b00) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    task automatic set_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
        req_we[i]          = we;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*8 +: 8] = d;
        req_valid[i]       = 1'b1;
    endtask

    // Raise a request, hold it until granted, drop it after the handshake edge.
    task automatic issue(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
        bit got;
        @(posedge clk); #1;
        set_req(i, we, a, d);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        chk("issue_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int n, output logic [1:0] v, output logic [7:0] d, output logic e);
        n = 0;
        v = 2'b00;
        d = 8'h00;
        e = 1'b0;
        while (v == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
            v = rsp_valid;
            d = rsp_rdata;
            e = rsp_err;
        end
        chk("rsp_arrived", 32'(v != 2'b00), 32'd1);
    endtask

    initial begin
        int         n, no, c0, c1, pulses;
        logic [1:0] v;
        logic [7:0] d, a;
        logic       e;
        logic [7:0] exp_order, order;
        bit         hs0, hs1, got;
        bit [1:0]   pend;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rx_valid", 32'(ram_rx_valid), 32'd0);
        chk("reset_ram_din", 32'(ram_din), 32'd0);

        // Write 0x3C <= 0xA5 from requester 0.
        issue(0, 1'b1, 8'h3C, 8'hA5);
        @(negedge clk); chk("wr_beat_addr", 32'(ram_din), 32'h03C);
        @(negedge clk); chk("wr_beat_data", 32'(ram_din), 32'h1A5);
        @(negedge clk); chk("wr_rsp_cycle3", 32'(rsp_valid), 32'h1);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);

        // Read 0x3C from requester 1.
        issue(1, 1'b0, 8'h3C, 8'h00);
        @(negedge clk); chk("rd_beat_addr", 32'(ram_din), 32'h23C);
        @(negedge clk); chk("rd_beat_data", 32'(ram_din), 32'h300);
        @(negedge clk); chk("rd_no_rsp_cycle3", 32'(rsp_valid), 32'h0);
        @(negedge clk); chk("rd_rsp_cycle4", 32'(rsp_valid), 32'h2);
        chk("rd_rdata", 32'(rsp_rdata), 32'hA5);
        chk("rd_err", 32'(rsp_err), 32'd0);

        // Both requesters contend for four writes each.
`ifdef SPI_RAM_ARB_RR_EN
        exp_order = 8'b1010_1010;
`else
        exp_order = 8'b1111_0000;
`endif
        order = 8'h00;
        no = 0; c0 = 0; c1 = 0;
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
        set_req(1, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
        for (int k = 0; k < 200 && no < 8; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                order[no] = rsp_valid[1];
                no++;
            end
            hs0 = req_valid[0] & req_ready[0];
            hs1 = req_valid[1] & req_ready[1];
            @(posedge clk); #1;
            if (hs0) begin
                c0++;
                if (c0 == 4) req_valid[0] = 1'b0;
                else set_req(0, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
            end
            if (hs1) begin
                c1++;
                if (c1 == 4) req_valid[1] = 1'b0;
                else set_req(1, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
            end
        end
        chk("arb_resp_count", 32'(no), 32'd8);
        chk("arb_order", 32'(order), 32'(exp_order));

        // Read timeout with a RAM that never answers.
        stub_dead = 1'b1;
        issue(0, 1'b0, 8'h21, 8'h00);
        wait_rsp(n, v, d, e);
        chk("to_latency", 32'(n), 32'(3 + RD_TIMEOUT));
        chk("to_owner", 32'(v), 32'h1);
        chk("to_err", 32'(e), 32'd1);
        chk("to_rdata", 32'(d), 32'h0);
        stub_dead = 1'b0;
        @(negedge clk); chk("to_pulse_width", 32'(rsp_valid), 32'h0);

        // Reset during the data beat of a write.
        issue(0, 1'b1, 8'h55, 8'h77);
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(negedge clk); chk("abort_in_data", 32'(ram_rx_valid), 32'd1);
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(negedge clk);
        chk("abort_rx_valid", 32'(ram_rx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid != 2'b00) pulses++;
            @(negedge clk);
        end
        chk("abort_no_rsp", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'h10, 8'h11);
        set_req(1, 1'b1, 8'h12, 8'h13);
        @(negedge clk); chk("post_reset_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        chk("post_reset_second", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (6) @(negedge clk);

        // Top address round trip.
        a = 8'($urandom);
        issue(1, 1'b1, 8'hFF, a);
        wait_rsp(n, v, d, e);
        chk("top_wr_owner", 32'(v), 32'h2);
        issue(0, 1'b0, 8'hFF, 8'h00);
        wait_rsp(n, v, d, e);
        chk("top_rd_data", 32'(d), 32'(a));
        @(negedge clk); chk("top_pulse_width", 32'(rsp_valid), 32'h0);

        // Random traffic; requests are held until granted.
        pend = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    req_valid[i] = 1'b0;
                    pend[i] = 1'b0;
                end
            end
            if (!m_act && req_valid == 2'b00 && $urandom_range(0, 49) == 0) stub_dead = ~stub_dead;
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
                    set_req(i, 1'($urandom), a, 8'($urandom));
                end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) pend[i] = 1'b1;
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        for (int k = 0; k < 20 && m_act; k++) @(negedge clk);
        @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
